lcd_text_page_show: RTL and testbench

- Parametrised text-page display engine for the ST7735 character path, successor to the fixed-string mode screens.
- Holds a COLS x ROWS character/attribute buffer written by any mode logic (music, clock, menu).
- Redraws only rows marked dirty, one character at a time, into the existing show-char renderer via the show_char_flag / show_char_done handshake.
- Colours come from a 4-entry attribute palette.

---
 rtl/lcd_text_pkg.sv | 53 +++++
 rtl/lcd_text_ram.sv | 27 ++
 rtl/lcd_text_page_show.sv | 267 ++++++++++++++++++++++++++
 tb/tb_lcd_text_page_show.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_text_pkg.sv
// Shared types and constants for the ST7735 text-page engine: cell layout,
// attribute palette, FSM states and the ASCII-to-font-index mapping.
package lcd_text_pkg;

  localparam int unsigned ASCII_OFFSET = 32;
  localparam logic [7:0]  SPACE_CODE   = 8'h20;
  localparam logic [7:0]  TILDE_CODE   = 8'h7E;

  localparam logic [15:0] PAL0_BG = 16'hE73F;
  localparam logic [15:0] PAL0_FG = 16'h0000;
  localparam logic [15:0] PAL1_BG = 16'hAF7D;
  localparam logic [15:0] PAL1_FG = 16'h0000;
  localparam logic [15:0] PAL2_BG = 16'h815B;
  localparam logic [15:0] PAL2_FG = 16'hFFFF;
  localparam logic [15:0] PAL3_BG = 16'hFA20;
  localparam logic [15:0] PAL3_FG = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  typedef struct packed {
    logic [7:0] chr;
    logic [1:0] attr;
  } cell_t;

  typedef struct packed {
    logic [15:0] bg;
    logic [15:0] fg;
  } colour_t;

  // Printable ASCII maps onto the font table; everything else renders as space.
  function automatic logic [7:0] ascii_index(input logic [7:0] c);
    if (c >= SPACE_CODE && c <= TILDE_CODE) return c - 8'(ASCII_OFFSET);
    return 8'h00;
  endfunction

  function automatic colour_t palette(input logic [1:0] attr);
    colour_t p;
    unique case (attr)
      2'd0:    p = '{bg: PAL0_BG, fg: PAL0_FG};
      2'd1:    p = '{bg: PAL1_BG, fg: PAL1_FG};
      2'd2:    p = '{bg: PAL2_BG, fg: PAL2_FG};
      default: p = '{bg: PAL3_BG, fg: PAL3_FG};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lcd_text_ram.sv
// Character/attribute buffer: one write port, one read port with registered
// read data (one-cycle latency). No reset; contents are set by the clear pass.
module lcd_text_ram
  import lcd_text_pkg::*;
#(
  parameter  int unsigned DEPTH = 160,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  cell_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output cell_t         rd_data
);

  cell_t mem_q [DEPTH];
  cell_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lcd_text_page_show.sv
// Text-page display engine: redraws dirty rows of a COLS x ROWS character
// buffer through the show-char renderer handshake. Optional blinking cursor
// is built when LCD_TEXT_CURSOR_EN is defined.
module lcd_text_page_show
  import lcd_text_pkg::*;
#(
  parameter  int unsigned COLS      = 20,
  parameter  int unsigned ROWS      = 8,
  parameter  int unsigned CHAR_W    = 8,
  parameter  int unsigned CHAR_H    = 16,
  parameter  int unsigned X0        = 0,
  parameter  int unsigned Y0        = 0,
  parameter  bit          EN_SIZE   = 1'b1,
`ifdef LCD_TEXT_CURSOR_EN
  parameter  int unsigned BLINK_CYC = 13_500_000,
`endif
  localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
`ifdef LCD_TEXT_CURSOR_EN
  input  logic             cur_en,
  input  logic [ROW_W-1:0] cur_row,
  input  logic [COL_W-1:0] cur_col,
`endif
  input  logic             init_done,
  input  logic             show_char_done,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [7:0]       wr_char,
  input  logic [1:0]       wr_attr,
  output logic             wr_ready,
  output logic             en_size,
  output logic             show_char_flag,
  output logic [7:0]       ascii_num,
  output logic [8:0]       start_x,
  output logic [8:0]       start_y,
  output logic [15:0]      background_color,
  output logic [15:0]      front_color,
  output logic             page_idle
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  if ((X0 + COLS * CHAR_W > 160) || (Y0 + ROWS * CHAR_H > 128)) begin : g_geom_check
    $error("lcd_text_page_show: text page does not fit the 160x128 panel");
  end

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROWS-1:0]  dirty_q, dirty_d;
  logic             show_char_flag_q, show_char_flag_d;
  logic [7:0]       ascii_num_q, ascii_num_d;
  logic [8:0]       start_x_q, start_x_d;
  logic [8:0]       start_y_q, start_y_d;
  logic [15:0]      bg_q, bg_d;
  logic [15:0]      fg_q, fg_d;
  logic             wr_ready_q, wr_ready_d;
  logic             page_idle_q, page_idle_d;

  logic             wr_hit_c;
  logic             ram_we_c;
  logic [AW-1:0]    ram_waddr_c;
  logic [AW-1:0]    ram_raddr_c;
  cell_t            ram_wdata_c;
  cell_t            ram_rdata;
  logic [ROW_W-1:0] pick_row_c;
  logic             swap_c;
  colour_t          pal_c;

  // Host writes land only outside the clear pass and only inside the page.
  assign wr_hit_c = wr_en && wr_ready_q &&
                    (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);

  always_comb begin
    ram_we_c    = wr_hit_c;
    ram_waddr_c = AW'(32'(wr_row) * COLS + 32'(wr_col));
    ram_wdata_c = '{chr: wr_char, attr: wr_attr};
    if (state_q == ST_CLEAR) begin
      ram_we_c    = 1'b1;
      ram_waddr_c = clr_idx_q;
      ram_wdata_c = '{chr: SPACE_CODE, attr: 2'd0};
    end
  end

  assign ram_raddr_c = AW'(32'(row_q) * COLS + 32'(col_q));

  lcd_text_ram #(
    .DEPTH (CELLS)
  ) u_ram (
    .clk     (sys_clk),
    .wr_en   (ram_we_c),
    .wr_addr (ram_waddr_c),
    .wr_data (ram_wdata_c),
    .rd_addr (ram_raddr_c),
    .rd_data (ram_rdata)
  );

  // Fixed-priority arbitration: lowest dirty row wins.
  always_comb begin
    pick_row_c = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (dirty_q[i]) pick_row_c = ROW_W'(i);
    end
  end

`ifdef LCD_TEXT_CURSOR_EN
  localparam int unsigned BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [ROW_W-1:0] cur_row_prev_q;
  logic [COL_W-1:0] cur_col_prev_q;
  logic             blink_tog_c;
  logic             cur_move_c;
  logic             cur_row_ok_c;

  always_comb begin
    blink_tog_c  = (32'(blink_cnt_q) == BLINK_CYC - 1);
    blink_cnt_d  = blink_tog_c ? '0 : blink_cnt_q + BW'(1);
    phase_d      = phase_q ^ blink_tog_c;
    cur_move_c   = (cur_row != cur_row_prev_q) || (cur_col != cur_col_prev_q);
    cur_row_ok_c = (32'(cur_row) < ROWS);
    swap_c       = cur_en && phase_q && (row_q == cur_row) && (col_q == cur_col);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blink_cnt_q    <= '0;
      phase_q        <= 1'b0;
      cur_row_prev_q <= '0;
      cur_col_prev_q <= '0;
    end else begin
      blink_cnt_q    <= blink_cnt_d;
      phase_q        <= phase_d;
      cur_row_prev_q <= cur_row;
      cur_col_prev_q <= cur_col;
    end
  end
`else
  assign swap_c = 1'b0;
`endif

  assign pal_c = palette(ram_rdata.attr);

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    clr_idx_d        = clr_idx_q;
    row_d            = row_q;
    col_d            = col_q;
    dirty_d          = dirty_q;
    show_char_flag_d = 1'b0;
    ascii_num_d      = ascii_num_q;
    start_x_d        = start_x_q;
    start_y_d        = start_y_q;
    bg_d             = bg_q;
    fg_d             = fg_q;

    unique case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (32'(clr_idx_q) == CELLS - 1) begin
          clr_idx_d = '0;
          dirty_d   = '1;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (init_done && (dirty_q != '0)) begin
          row_d   = pick_row_c;
          col_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (col_q == '0) dirty_d[row_q] = 1'b0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        ascii_num_d      = ascii_index(ram_rdata.chr);
        start_x_d        = 9'(X0 + 32'(col_q) * CHAR_W);
        start_y_d        = 9'(Y0 + 32'(row_q) * CHAR_H);
        bg_d             = swap_c ? pal_c.fg : pal_c.bg;
        fg_d             = swap_c ? pal_c.bg : pal_c.fg;
        show_char_flag_d = 1'b1;
        state_d          = ST_WAIT;
      end
      ST_WAIT: begin
        if (show_char_done) begin
          if (32'(col_q) == COLS - 1) begin
            state_d = ST_IDLE;
          end else if (!init_done) begin
            // Panel went away mid-row: park and redraw the whole row later.
            dirty_d[row_q] = 1'b1;
            state_d        = ST_IDLE;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase

`ifdef LCD_TEXT_CURSOR_EN
    if (blink_tog_c && cur_row_ok_c) dirty_d[cur_row] = 1'b1;
    if (cur_move_c) begin
      if (32'(cur_row_prev_q) < ROWS) dirty_d[cur_row_prev_q] = 1'b1;
      if (cur_row_ok_c) dirty_d[cur_row] = 1'b1;
    end
`endif
    // A write wins over a same-cycle dirty clear so the row is drawn again.
    if (wr_hit_c) dirty_d[wr_row] = 1'b1;

    wr_ready_d  = (state_d != ST_CLEAR);
    page_idle_d = (state_d == ST_IDLE) && (dirty_d == '0);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q          <= ST_CLEAR;
      clr_idx_q        <= '0;
      row_q            <= '0;
      col_q            <= '0;
      dirty_q          <= '0;
      show_char_flag_q <= 1'b0;
      ascii_num_q      <= 8'h00;
      start_x_q        <= 9'd0;
      start_y_q        <= 9'd0;
      bg_q             <= PAL0_BG;
      fg_q             <= PAL0_FG;
      wr_ready_q       <= 1'b0;
      page_idle_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      clr_idx_q        <= clr_idx_d;
      row_q            <= row_d;
      col_q            <= col_d;
      dirty_q          <= dirty_d;
      show_char_flag_q <= show_char_flag_d;
      ascii_num_q      <= ascii_num_d;
      start_x_q        <= start_x_d;
      start_y_q        <= start_y_d;
      bg_q             <= bg_d;
      fg_q             <= fg_d;
      wr_ready_q       <= wr_ready_d;
      page_idle_q      <= page_idle_d;
    end
  end

  assign en_size          = EN_SIZE;
  assign wr_ready         = wr_ready_q;
  assign show_char_flag   = show_char_flag_q;
  assign ascii_num        = ascii_num_q;
  assign start_x          = start_x_q;
  assign start_y          = start_y_q;
  assign background_color = bg_q;
  assign front_color      = fg_q;
  assign page_idle        = page_idle_q;

endmodule

// File: tb/tb_lcd_text_page_show.sv
// Scoreboard bench for lcd_text_page_show: a shadow page model predicts every
// glyph request; a renderer model answers with show_char_done.
module tb_lcd_text_page_show;

  localparam int COLS = 20;
  localparam int ROWS = 8;

  typedef struct packed {
    logic [7:0]  ascii;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] bg;
    logic [15:0] fg;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        show_char_done = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_row = '0;
  logic [4:0]  wr_col = '0;
  logic [7:0]  wr_char = '0;
  logic [1:0]  wr_attr = '0;
  logic        wr_ready, en_size, show_char_flag, page_idle;
  logic [7:0]  ascii_num;
  logic [8:0]  start_x, start_y;
  logic [15:0] background_color, front_color;

  lcd_text_page_show dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
`ifdef LCD_TEXT_CURSOR_EN
    .cur_en           (1'b0),
    .cur_row          (3'd0),
    .cur_col          (5'd0),
`endif
    .init_done        (init_done),
    .show_char_done   (show_char_done),
    .wr_en            (wr_en),
    .wr_row           (wr_row),
    .wr_col           (wr_col),
    .wr_char          (wr_char),
    .wr_attr          (wr_attr),
    .wr_ready         (wr_ready),
    .en_size          (en_size),
    .show_char_flag   (show_char_flag),
    .ascii_num        (ascii_num),
    .start_x          (start_x),
    .start_y          (start_y),
    .background_color (background_color),
    .front_color      (front_color),
    .page_idle        (page_idle)
  );

  always #5 sys_clk = ~sys_clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [7:0]  sh_char [ROWS][COLS];
  logic [1:0]  sh_attr [ROWS][COLS];
  bit          dirty_m [ROWS];
  logic [15:0] pal_bg [4] = '{16'hE73F, 16'hAF7D, 16'h815B, 16'hFA20};
  logic [15:0] pal_fg [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
  bit          spurious_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_cell(input int r, input int c);
    exp_t e;
    int   ch;
    ch      = int'(sh_char[r][c]);
    e.ascii = (ch >= 32 && ch <= 126) ? 8'(ch - 32) : 8'd0;
    e.x     = 9'(c * 8);
    e.y     = 9'(r * 16);
    e.bg    = pal_bg[sh_attr[r][c]];
    e.fg    = pal_fg[sh_attr[r][c]];
    return e;
  endfunction

  task automatic push_row(input int r, input int first, input int last);
    for (int c = first; c <= last; c++) sb_q.push_back(model_cell(r, c));
  endtask

  // Predict a redraw of every dirty row, lowest row first.
  task automatic flush();
    for (int r = 0; r < ROWS; r++) begin
      if (dirty_m[r]) begin
        push_row(r, 0, COLS - 1);
        dirty_m[r] = 1'b0;
      end
    end
  endtask

  // Called at a falling edge; the write is sampled on the next rising edge.
  task automatic do_write(input int r, input int c, input int ch, input int a);
    wr_en   = 1'b1;
    wr_row  = 3'(r);
    wr_col  = 5'(c);
    wr_char = 8'(ch);
    wr_attr = 2'(a);
    if (r < ROWS && c < COLS) begin
      sh_char[r][c] = 8'(ch);
      sh_attr[r][c] = 2'(a);
      dirty_m[r]    = 1'b1;
    end
    @(negedge sys_clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(page_idle && sb_q.size() == 0) && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    check($sformatf("%s_page_idle", name), 64'(page_idle), 64'd1);
    check($sformatf("%s_pending", name), 64'(sb_q.size()), 64'd0);
  endtask

  task automatic wait_flag_at(input string name, input int x, input int y);
    int n = 0;
    while (!(show_char_flag && start_x == 9'(x) && start_y == 9'(y)) && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    check($sformatf("%s_reached", name), 64'(n < 20000), 64'd1);
  endtask

  // Scoreboard monitor: every request pulse is compared with the next prediction.
  always @(negedge sys_clk) begin
    if (sys_rst_n && show_char_flag) begin
      if (sb_q.size() == 0) begin
        check("unexpected_glyph", {start_x, start_y}, 64'h0);
        if ({start_x, start_y} == 18'h0) begin
          errors++;
          $display("FAIL unexpected_glyph actual=request required=none at %0t", $time);
        end
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ascii_num", 64'(ascii_num), 64'(e.ascii));
        check("start_x", 64'(start_x), 64'(e.x));
        check("start_y", 64'(start_y), 64'(e.y));
        check("background_color", 64'(background_color), 64'(e.bg));
        check("front_color", 64'(front_color), 64'(e.fg));
      end
    end
  end

  // Renderer model: random latency, verifies outputs hold until done.
  bit         rend_busy = 1'b0;
  int         rend_cnt = 0;
  logic [57:0] held;
  always @(negedge sys_clk) begin
    show_char_done = 1'b0;
    if (rend_busy) begin
      if (rend_cnt == 0) begin
        check("hold_until_done",
              64'({ascii_num, start_x, start_y, background_color, front_color}), 64'(held));
        show_char_done = 1'b1;
        rend_busy      = 1'b0;
      end else begin
        rend_cnt--;
      end
    end else if (sys_rst_n && show_char_flag) begin
      rend_busy = 1'b1;
      rend_cnt  = int'($urandom_range(2, 0));
      held      = {ascii_num, start_x, start_y, background_color, front_color};
    end else if (spurious_req) begin
      show_char_done = 1'b1;
      spurious_req   = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < ROWS; r++) begin
      dirty_m[r] = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        sh_char[r][c] = 8'h20;
        sh_attr[r][c] = 2'd0;
      end
    end
    init_done = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_show_char_flag", 64'(show_char_flag), 64'd0);
    check("rst_ascii_num", 64'(ascii_num), 64'd0);
    check("rst_start_x", 64'(start_x), 64'd0);
    check("rst_start_y", 64'(start_y), 64'd0);
    check("rst_background", 64'(background_color), 64'hE73F);
    check("rst_front", 64'(front_color), 64'h0000);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_page_idle", 64'(page_idle), 64'd0);
    check("en_size", 64'(en_size), 64'd1);

    // Whole page is blank-drawn after the clear pass.
    for (int r = 0; r < ROWS; r++) push_row(r, 0, COLS - 1);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("clear_wr_ready", 64'(wr_ready), 64'd0);
    check("clear_page_idle", 64'(page_idle), 64'd0);
    wait_idle("init");
    check("post_clear_wr_ready", 64'(wr_ready), 64'd1);

    // Single cell write redraws only its row.
    do_write(2, 3, 77, 1);
    flush();
    wait_idle("single_write");

    // Write to the very cell being drawn: held outputs untouched, row drawn again.
    do_write(5, 0, 81, 3);
    flush();
    wait_flag_at("row5_col10", 80, 80);
    do_write(5, 10, 90, 2);
    flush();
    wait_idle("mid_draw_write");

    // init_done drops mid-row: finish current glyph, then full row redraw later.
    do_write(4, 0, 65, 0);
    push_row(4, 0, 7);
    wait_flag_at("row4_col7", 56, 64);
    init_done = 1'b0;
    repeat (30) @(negedge sys_clk);
    check("stalled_page_idle", 64'(page_idle), 64'd0);
    check("stalled_pending", 64'(sb_q.size()), 64'd0);
    flush();
    init_done = 1'b1;
    wait_idle("init_done_drop");

    // Batched random writes, incl. non-printables and out-of-range columns.
    for (int round = 0; round < 4; round++) begin
      init_done = 1'b0;
      @(negedge sys_clk);
      if (round == 0) begin
        do_write(6, 5, 8'h0A, 2);
        do_write(1, 7, 8'hFF, 3);
      end
      for (int k = 0; k < 8; k++)
        do_write(int'($urandom_range(7, 0)), int'($urandom_range(23, 0)),
                 int'($urandom_range(255, 0)), int'($urandom_range(3, 0)));
      flush();
      init_done = 1'b1;
      wait_idle($sformatf("batch%0d", round));
    end

    // A done pulse outside WAIT must not start anything.
    spurious_req = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("spurious_done_idle", 64'(page_idle), 64'd1);
    check("spurious_done_pending", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
